div_unit: RTL and testbench

//  Parametrised iterative divider for DIV/DIVU. Signed or unsigned, restoring, one quotient bit per clock.

---
 rtl/div_unit_pkg.sv | 17 +
 rtl/div_unit.sv | 97 +++++++++
 tb/tb_div_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// div_unit_pkg: divider state codes, handshake levels and the aluop codes that select DIV/DIVU
package div_unit_pkg;
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_t;
  localparam logic RstEnable = 1'b0;
  localparam logic [31:0] ZeroWord = 32'h0;
  localparam logic DivResultReady = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart = 1'b1;
  localparam logic DivStop = 1'b0;
  localparam logic [7:0] EXE_DIV_OP = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;
endpackage

// File: rtl/div_unit.sv
// div_unit: restoring signed/unsigned divider, one quotient bit per clock, result packed {rem, quo}.
// Define DIV_ANNUL_EN to let annul_i abandon an in-flight divide.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);
  div_state_t state, state_nxt;
  logic [2*WIDTH:0] dvd, dvd_nxt;
  logic [WIDTH-1:0] dvs, dvs_nxt, mag1, mag2, quo, rem;
  logic [WIDTH:0] trial;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic s1, s2, s1_nxt, s2_nxt, neg1, neg2, ready_nxt, annul, go;
  logic [2*WIDTH-1:0] result_nxt;
`ifdef DIV_ANNUL_EN
  assign annul = annul_i;
`else
  assign annul = annul_i & 1'b0;
`endif
  assign go = start_i == DivStart;
  assign neg1 = signed_div_i & opdata1_i[WIDTH-1];
  assign neg2 = signed_div_i & opdata2_i[WIDTH-1];
  assign mag1 = neg1 ? -opdata1_i : opdata1_i;
  assign mag2 = neg2 ? -opdata2_i : opdata2_i;
  assign quo = dvd[WIDTH-1:0];
  assign rem = dvd[2*WIDTH-1:WIDTH];
  // remainder after the left shift, minus divisor; bit WIDTH set means the trial went negative
  assign trial = dvd[2*WIDTH-1:WIDTH-1] - {1'b0, dvs};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DivFree;
      dvd      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      s1       <= 1'b0;
      s2       <= 1'b0;
      ready_o  <= DivResultNotReady;
      result_o <= '0;
    end else begin
      state    <= state_nxt;
      dvd      <= dvd_nxt;
      dvs      <= dvs_nxt;
      cnt      <= cnt_nxt;
      s1       <= s1_nxt;
      s2       <= s2_nxt;
      ready_o  <= ready_nxt;
      result_o <= result_nxt;
    end
  end
  always_comb begin
    state_nxt  = state;
    dvd_nxt    = dvd;
    dvs_nxt    = dvs;
    cnt_nxt    = cnt;
    s1_nxt     = s1;
    s2_nxt     = s2;
    ready_nxt  = DivResultNotReady;
    result_nxt = '0;
    case (state)
      DivFree: if (go) begin
        state_nxt = (opdata2_i == '0) ? DivByZero : DivOn;
        dvd_nxt   = {{(WIDTH+1){1'b0}}, mag1};
        dvs_nxt   = mag2;
        s1_nxt    = neg1;
        s2_nxt    = neg2;
        cnt_nxt   = '0;
      end
      DivByZero: begin
        state_nxt = annul ? DivFree : DivEnd;
        dvd_nxt   = '0;
      end
      DivOn: if (annul) state_nxt = DivFree;
      else begin
        dvd_nxt   = trial[WIDTH] ? {dvd[2*WIDTH-1:0], 1'b0} : {trial, dvd[WIDTH-2:0], 1'b1};
        cnt_nxt   = cnt + 1'b1;
        state_nxt = (cnt == CNT_W'(WIDTH - 1)) ? DivEnd : DivOn;
      end
      DivEnd: begin
        state_nxt  = go ? DivEnd : DivFree;
        ready_nxt  = go ? DivResultReady : DivResultNotReady;
        result_nxt = go ? {(s1 ? -rem : rem), ((s1 ^ s2) ? -quo : quo)} : '0;
      end
      default: state_nxt = DivFree;
    endcase
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and randomized checks of div_unit against an arithmetic reference model.
// Define DIV_ANNUL_EN here as for the RTL to exercise the annul path.
module tb_div_unit;
  localparam int W = 32;
  logic clk = 1'b0, rst = 1'b0, signed_div_i = 1'b0, start_i = 1'b0, annul_i = 1'b0;
  logic [W-1:0] opdata1_i = '0, opdata2_i = '0;
  logic [2*W-1:0] result_o;
  logic ready_o;
  int compared = 0, mismatched = 0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i), .opdata1_i(opdata1_i),
    .opdata2_i(opdata2_i), .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // truncating division with remainder following the dividend, as C/MIPS define it
  function automatic logic [63:0] model(input bit sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'h0) return 64'h0;
    sa = sg ? longint'($signed(a)) : longint'(a);
    sb = sg ? longint'($signed(b)) : longint'(b);
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic start_op(input bit sg, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    signed_div_i = sg; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
  endtask

  // returns the number of edges consumed until ready_o is seen; operands are scrambled meanwhile
  task automatic wait_ready(output int n);
    n = 0;
    for (int i = 0; i < W + 10; i++) begin
      @(posedge clk); #1;
      n++;
      opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = 1'($urandom);
      if (ready_o) break;
    end
  endtask

  task automatic run_div(input string tag, input bit sg, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int hold);
    int n;
    start_op(sg, a, b);
    wait_ready(n);
    chk({tag, " latency"}, 64'(n - 1), (b == 32'h0) ? 64'd2 : 64'(W + 1));
    chk({tag, " result"}, result_o, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, " hold ready"}, 64'(ready_o), 64'd1);
      chk({tag, " hold result"}, result_o, exp);
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    chk({tag, " drop ready"}, 64'(ready_o), 64'd0);
    chk({tag, " drop result"}, result_o, 64'h0);
  endtask

  initial begin
    int n, seen;
    bit sg;
    logic [31:0] a, b;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", 64'(ready_o), 64'd0);
    chk("reset result", result_o, 64'h0);
    rst = 1'b1;

    run_div("divu 100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1);
    run_div("div -100/7", 1'b1, -32'sd100, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2}, 0);
    run_div("div 7/-2", 1'b1, 32'd7, -32'sd2, {32'd1, 32'hFFFFFFFD}, 0);
    run_div("div -7/2", 1'b1, -32'sd7, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 0);
    run_div("div overflow", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 0);
    run_div("divu min/max", 1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'h0}, 0);
    run_div("divu 5/0", 1'b0, 32'd5, 32'd0, 64'h0, 1);

`ifdef DIV_ANNUL_EN
    start_op(1'b0, 32'd100, 32'd7);
    repeat (11) @(posedge clk);
    #1;
    annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    annul_i = 1'b0;
    seen = 0;
    repeat (W + 8) begin
      @(posedge clk); #1;
      seen |= int'(ready_o);
    end
    chk("annul no ready", 64'(seen), 64'd0);
    run_div("after annul 9/3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 0);
`else
    start_op(1'b0, 32'd100, 32'd7);
    repeat (11) @(posedge clk);
    #1;
    annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0;
    wait_ready(n);
    chk("annul ignored latency", 64'(n + 11), 64'(W + 1));
    chk("annul ignored result", result_o, {32'd2, 32'd14});
    start_i = 1'b0;
    @(posedge clk); #1;
`endif

    start_op(1'b0, 32'd100, 32'd7);
    repeat (21) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("mid-op reset ready", 64'(ready_o), 64'd0);
    chk("mid-op reset result", result_o, 64'h0);
    start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    run_div("div 1/1 after reset", 1'b1, 32'd1, 32'd1, {32'd0, 32'd1}, 5);

    start_op(1'b0, 32'd9, 32'd3);
    wait_ready(n);
    chk("pre-reset ready", 64'(ready_o), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async reset ready", 64'(ready_o), 64'd0);
    chk("async reset result", result_o, 64'h0);
    start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 40; i++) begin
      sg = 1'($urandom);
      case ($urandom % 4)
        0: a = $urandom;
        1: a = $urandom % 1000;
        2: a = 32'h80000000;
        default: a = -($urandom % 1000);
      endcase
      case ($urandom % 5)
        0: b = 32'h0;
        1: b = $urandom % 20 + 1;
        2: b = 32'hFFFFFFFF;
        3: b = -($urandom % 20 + 1);
        default: b = $urandom;
      endcase
      run_div($sformatf("rand%0d %s %h/%h", i, sg ? "div" : "divu", a, b), sg, a, b, model(sg, a, b), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
